// File: rtl/button_conditioner.sv
// Input conditioner for the multiplier front panel: synchronises the raw keys and switches,
// debounces each key, and emits active-high levels plus one-cycle press strobes.
module button_conditioner #(
   parameter int unsigned SW_WIDTH        = 8,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic                Clk,
   input  logic                Reset_n,
   input  logic                Run,
   input  logic                Reset_Load_Clear,
   input  logic [SW_WIDTH-1:0] SW,
   output logic                Run_Level,
   output logic                Clr_Ld_Level,
   output logic                Run_Pulse,
   output logic                Clr_Ld_Pulse,
   output logic [SW_WIDTH-1:0] SW_Sync
);

   localparam int unsigned CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned NUM_KEYS = 2;
   localparam int unsigned RUN_IDX  = 0;
   localparam int unsigned CLR_IDX  = 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      WAIT_PRESS   = 2'd1,
      PRESSED      = 2'd2,
      WAIT_RELEASE = 2'd3
   } key_state_e;

   logic [NUM_KEYS-1:0]    key_raw;
   logic [SYNC_STAGES-1:0] key_sync_q [NUM_KEYS];
   logic [NUM_KEYS-1:0]    key_s;
   logic [SW_WIDTH-1:0]    sw_sync_q  [SYNC_STAGES];

   key_state_e             state_q [NUM_KEYS];
   key_state_e             state_d [NUM_KEYS];
   logic [CNT_W-1:0]       cnt_q   [NUM_KEYS];
   logic [CNT_W-1:0]       cnt_d   [NUM_KEYS];
   logic [NUM_KEYS-1:0]    level_q;
   logic [NUM_KEYS-1:0]    level_d;
   logic [NUM_KEYS-1:0]    pulse_d;
   logic                   clr_pulse_q;
   logic                   run_pulse_q;
   logic                   run_pulse_d;

   assign key_raw = {Reset_Load_Clear, Run};

   // Synchronisers: keys idle high (released), switches idle low.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int k = 0; k < NUM_KEYS; k++) key_sync_q[k] <= '1;
         for (int i = 0; i < SYNC_STAGES; i++) sw_sync_q[i] <= '0;
      end else begin
         for (int k = 0; k < NUM_KEYS; k++)
            key_sync_q[k] <= {key_sync_q[k][SYNC_STAGES-2:0], key_raw[k]};
         sw_sync_q[0] <= SW;
         for (int i = 1; i < SYNC_STAGES; i++) sw_sync_q[i] <= sw_sync_q[i-1];
      end
   end

   // Debounce FSMs; key_s is the synchronised active-low key.
   always_comb begin
      for (int k = 0; k < NUM_KEYS; k++) begin
         state_d[k] = state_q[k];
         cnt_d[k]   = cnt_q[k];
         pulse_d[k] = 1'b0;
         key_s[k]   = key_sync_q[k][SYNC_STAGES-1];
         case (state_q[k])
            RELEASED: begin
               if (!key_s[k]) begin
                  state_d[k] = WAIT_PRESS;
                  cnt_d[k]   = '0;
               end
            end
            WAIT_PRESS: begin
               if (key_s[k]) begin
                  state_d[k] = RELEASED;
               end else if (cnt_q[k] == CNT_LAST) begin
                  state_d[k] = PRESSED;
                  pulse_d[k] = 1'b1;
               end else begin
                  cnt_d[k] = cnt_q[k] + CNT_W'(1);
               end
            end
            PRESSED: begin
               if (key_s[k]) begin
                  state_d[k] = WAIT_RELEASE;
                  cnt_d[k]   = '0;
               end
            end
            WAIT_RELEASE: begin
               if (!key_s[k]) begin
                  state_d[k] = PRESSED;
               end else if (cnt_q[k] == CNT_LAST) begin
                  state_d[k] = RELEASED;
               end else begin
                  cnt_d[k] = cnt_q[k] + CNT_W'(1);
               end
            end
            default: state_d[k] = RELEASED;
         endcase
         level_d[k] = (state_d[k] == PRESSED) || (state_d[k] == WAIT_RELEASE);
      end
      // Clear/Load wins: a Run press landing while Clear is held or strobing is dropped.
      run_pulse_d = pulse_d[RUN_IDX] & ~level_d[CLR_IDX] & ~pulse_d[CLR_IDX];
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int k = 0; k < NUM_KEYS; k++) begin
            state_q[k] <= RELEASED;
            cnt_q[k]   <= '0;
         end
         level_q     <= '0;
         clr_pulse_q <= 1'b0;
         run_pulse_q <= 1'b0;
      end else begin
         for (int k = 0; k < NUM_KEYS; k++) begin
            state_q[k] <= state_d[k];
            cnt_q[k]   <= cnt_d[k];
         end
         level_q     <= level_d;
         clr_pulse_q <= pulse_d[CLR_IDX];
         run_pulse_q <= run_pulse_d;
      end
   end

   assign Run_Level    = level_q[RUN_IDX];
   assign Clr_Ld_Level = level_q[CLR_IDX];
   assign Run_Pulse    = run_pulse_q;
   assign Clr_Ld_Pulse = clr_pulse_q;
   assign SW_Sync      = sw_sync_q[SYNC_STAGES-1];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed vector table, hand sequences for reset/latency corners,
// and randomized keys/switches against a streak-counting reference model.
module tb_button_conditioner;

   localparam int unsigned SW_W = 8;
   localparam int unsigned SYNC = 2;
   localparam int unsigned DEB  = 4;

   logic            Clk = 1'b0;
   logic            Reset_n;
   logic            Run;
   logic            Reset_Load_Clear;
   logic [SW_W-1:0] SW;
   logic            Run_Level, Clr_Ld_Level, Run_Pulse, Clr_Ld_Pulse;
   logic [SW_W-1:0] SW_Sync;
   logic            Run_Level3, Clr_Ld_Level3, Run_Pulse3, Clr_Ld_Pulse3;
   logic [SW_W-1:0] SW_Sync3;

   button_conditioner #(.SW_WIDTH(SW_W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Reset_Load_Clear(Reset_Load_Clear), .SW(SW),
      .Run_Level(Run_Level), .Clr_Ld_Level(Clr_Ld_Level), .Run_Pulse(Run_Pulse),
      .Clr_Ld_Pulse(Clr_Ld_Pulse), .SW_Sync(SW_Sync));

   button_conditioner #(.SW_WIDTH(SW_W), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(DEB)) dut3 (
      .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Reset_Load_Clear(Reset_Load_Clear), .SW(SW),
      .Run_Level(Run_Level3), .Clr_Ld_Level(Clr_Ld_Level3), .Run_Pulse(Run_Pulse3),
      .Clr_Ld_Pulse(Clr_Ld_Pulse3), .SW_Sync(SW_Sync3));

   always #5 Clk = ~Clk;

   int vectors     = 0;
   int miscompares = 0;

   task automatic check1(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check8(input string name, input logic [SW_W-1:0] act, input logic [SW_W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: raw samples delayed through queues; a key's accepted level flips once
   // the synchronised key has disagreed with it on DEB+1 consecutive edges.
   bit              m_rq[$], m_cq[$];
   logic [SW_W-1:0] m_sw2[$], m_sw3[$];
   bit              m_rl, m_cl, m_rp, m_cp;
   int              m_rs, m_cs;

   task automatic model_reset();
      m_rq.delete(); m_cq.delete(); m_sw2.delete(); m_sw3.delete();
      repeat (SYNC) begin m_rq.push_back(1'b1); m_cq.push_back(1'b1); m_sw2.push_back('0); end
      repeat (3) m_sw3.push_back('0);
      m_rl = 0; m_cl = 0; m_rp = 0; m_cp = 0; m_rs = 0; m_cs = 0;
   endtask

   task automatic key_update(input bit s, inout bit lvl, inout int streak, output bit rose);
      rose = 0;
      if (s == lvl) begin
         streak++;
         if (streak == int'(DEB) + 1) begin
            lvl    = !lvl;
            streak = 0;
            rose   = lvl;
         end
      end else begin
         streak = 0;
      end
   endtask

   task automatic model_step();
      bit s_r, s_c, rr, cr;
      s_r = m_rq[$];
      s_c = m_cq[$];
      m_rq.push_front(Run);              void'(m_rq.pop_back());
      m_cq.push_front(Reset_Load_Clear); void'(m_cq.pop_back());
      m_sw2.push_front(SW);              void'(m_sw2.pop_back());
      m_sw3.push_front(SW);              void'(m_sw3.pop_back());
      key_update(s_r, m_rl, m_rs, rr);
      key_update(s_c, m_cl, m_cs, cr);
      m_cp = cr;
      m_rp = rr && !m_cl;
   endtask

   task automatic tick();
      @(posedge Clk);
      model_step();
      #1;
      check1("model_run_level", Run_Level, m_rl);
      check1("model_run_pulse", Run_Pulse, m_rp);
      check1("model_clr_level", Clr_Ld_Level, m_cl);
      check1("model_clr_pulse", Clr_Ld_Pulse, m_cp);
      check8("model_sw_sync", SW_Sync, m_sw2[$]);
      check8("model_sw_sync3", SW_Sync3, m_sw3[$]);
   endtask

   task automatic check_zero(input string tag);
      check1({tag, "_run_level"}, Run_Level, 1'b0);
      check1({tag, "_run_pulse"}, Run_Pulse, 1'b0);
      check1({tag, "_clr_level"}, Clr_Ld_Level, 1'b0);
      check1({tag, "_clr_pulse"}, Clr_Ld_Pulse, 1'b0);
      check8({tag, "_sw_sync"}, SW_Sync, '0);
      check1({tag, "_run_level3"}, Run_Level3, 1'b0);
      check1({tag, "_clr_pulse3"}, Clr_Ld_Pulse3, 1'b0);
      check8({tag, "_sw_sync3"}, SW_Sync3, '0);
   endtask

   // Assert reset between edges, check the async clear, hold, then release with given inputs.
   task automatic do_reset(input bit run_v, input bit clr_v, input logic [SW_W-1:0] sw_v);
      Reset_n = 1'b0;
      #1;
      check_zero("rst_async");
      model_reset();
      repeat (2) @(posedge Clk);
      #1;
      check_zero("rst_hold");
      Run = run_v; Reset_Load_Clear = clr_v; SW = sw_v;
      Reset_n = 1'b1;
   endtask

   typedef struct {
      bit run; bit clr;
      bit rl;  bit rp;  bit cl;  bit cp;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input bit run, input bit clr, input bit rl, input bit rp,
                      input bit cl, input bit cp, input int n);
      vec_t v;
      v.run = run; v.clr = clr; v.rl = rl; v.rp = rp; v.cl = cl; v.cp = cp;
      repeat (n) tbl.push_back(v);
   endtask

   initial begin
      int rl_left, cl_left;
      Reset_n = 1'b1; Run = 1'b0; Reset_Load_Clear = 1'b0; SW = 8'h3C;

      // Press, release, bounce, simultaneous press, lone Run press (row i drives before edge i).
      add(0,1, 0,0,0,0, 6); add(0,1, 1,1,0,0, 1); add(0,1, 1,0,0,0, 1);
      add(1,1, 1,0,0,0, 6); add(1,1, 0,0,0,0, 2);
      add(0,1, 0,0,0,0, 3); add(1,1, 0,0,0,0, 1); add(0,1, 0,0,0,0, 6);
      add(0,1, 1,1,0,0, 1); add(0,1, 1,0,0,0, 1);
      add(1,1, 1,0,0,0, 6); add(1,1, 0,0,0,0, 1);
      add(0,0, 0,0,0,0, 6); add(0,0, 1,0,1,1, 1); add(0,0, 1,0,1,0, 1);
      add(1,1, 1,0,1,0, 6); add(1,1, 0,0,0,0, 2);
      add(0,1, 0,0,0,0, 6); add(0,1, 1,1,0,0, 1); add(1,1, 1,0,0,0, 1);

      // Async reset with arbitrary inputs, then idle keys keep outputs low.
      #2;
      do_reset(1'b1, 1'b1, 8'h00);
      for (int i = 0; i < 4; i++) begin
         tick();
         check1("idle_run_level", Run_Level, 1'b0);
         check1("idle_clr_level", Clr_Ld_Level, 1'b0);
      end

      foreach (tbl[i]) begin
         Run = tbl[i].run; Reset_Load_Clear = tbl[i].clr;
         tick();
         check1($sformatf("tbl%0d_run_level", i + 1), Run_Level, tbl[i].rl);
         check1($sformatf("tbl%0d_run_pulse", i + 1), Run_Pulse, tbl[i].rp);
         check1($sformatf("tbl%0d_clr_level", i + 1), Clr_Ld_Level, tbl[i].cl);
         check1($sformatf("tbl%0d_clr_pulse", i + 1), Clr_Ld_Pulse, tbl[i].cp);
      end

      // Switch synchroniser depth for 2 and 3 stages.
      repeat (3) tick();
      SW = 8'hA5;
      tick(); check8("sw_e1", SW_Sync, 8'h00); check8("sw3_e1", SW_Sync3, 8'h00);
      tick(); check8("sw_e2", SW_Sync, 8'hA5); check8("sw3_e2", SW_Sync3, 8'h00);
      tick(); check8("sw3_e3", SW_Sync3, 8'hA5);

      // Reset mid-debounce aborts the press; key held through reset gives one fresh pulse.
      do_reset(1'b1, 1'b1, 8'h5A);
      Run = 1'b0;
      for (int e = 1; e <= 5; e++) begin
         tick();
         check1("t5_pre_pulse", Run_Pulse, 1'b0);
      end
      do_reset(1'b0, 1'b1, 8'h5A);
      for (int e = 1; e <= 8; e++) begin
         tick();
         check1($sformatf("t5_e%0d_pulse", e), Run_Pulse, e == 7);
         check1($sformatf("t5_e%0d_level", e), Run_Level, e >= 7);
      end

      // Randomized key hold lengths and switches, with occasional resets.
      rl_left = 0; cl_left = 0;
      for (int n = 0; n < 3000; n++) begin
         if (rl_left == 0) begin
            Run = 1'($urandom_range(0, 1)); rl_left = int'($urandom_range(1, 12));
         end else rl_left--;
         if (cl_left == 0) begin
            Reset_Load_Clear = 1'($urandom_range(0, 1)); cl_left = int'($urandom_range(1, 16));
         end else cl_left--;
         SW = SW_W'($urandom);
         if (n % 1000 == 999) do_reset(Run, Reset_Load_Clear, SW);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
